// File: rtl/multi_cycle_control_unit.sv
// rtl/multi_cycle_control_unit.sv - RV32I multi-cycle control FSM with bounded memory waits
// Define ILLEGAL_TRAP_EN to trap on unrecognised opcodes; otherwise they retire as NOPs.
module multi_cycle_control_unit #(
  parameter int ALU_CTRL_W   = 4,
  parameter int WAIT_TIMEOUT = 255,
  parameter int TO_CNT_W     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           instrCode,
  input  logic                  imemReady,
  input  logic                  dmemReady,
  output logic                  imemReq,
  output logic                  irLoad,
  output logic                  pcEn,
  output logic                  regFileWe,
  output logic                  aluSrcSel,
  output logic [ALU_CTRL_W-1:0] aluControl,
  output logic [2:0]            rfWdSel,
  output logic [1:0]            pcSrcSel,
  output logic                  branch,
  output logic                  dataRe,
  output logic                  dataWe,
  output logic                  illegalInstr,
  output logic                  busError
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_TRAP
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SRL  = 4'd3;
  localparam logic [3:0] ALU_SRA  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_XOR  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  state_t              state_q, state_d;
  logic [TO_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                bus_error_q, bus_error_d;
  logic                illegal_q, illegal_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_r, is_i, is_load, is_store, is_branch, is_lui, is_auipc, is_jal, is_jalr;
  logic       known, waiting, timeout;
  logic [3:0] alu_sel, alu_op;
  logic       unused_instr_bits;

  assign opcode    = instrCode[6:0];
  assign funct3    = instrCode[14:12];
  assign is_r      = (opcode == OP_R);
  assign is_i      = (opcode == OP_I);
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_lui    = (opcode == OP_LUI);
  assign is_auipc  = (opcode == OP_AUIPC);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);
  assign known     = is_r | is_i | is_load | is_store | is_branch |
                     is_lui | is_auipc | is_jal | is_jalr;
  assign unused_instr_bits = ^{instrCode[31], instrCode[29:15], instrCode[11:7]};

  // The counter sits at WAIT_TIMEOUT only on the last cycle a late ready can still rescue.
  assign waiting = ((state_q == S_FETCH) && !imemReady) || ((state_q == S_MEM) && !dmemReady);
  assign timeout = (WAIT_TIMEOUT != 0) && waiting && (wait_cnt_q == TO_CNT_W'(WAIT_TIMEOUT));

  always_comb begin
    alu_sel = {1'b0, funct3};
    if (is_r || (is_i && funct3 == 3'b101))
      alu_sel = {instrCode[30], funct3};
    alu_op = ALU_ADD;
    if (is_r || is_i) begin
      case (alu_sel)
        4'b0_000: alu_op = ALU_ADD;
        4'b1_000: alu_op = ALU_SUB;
        4'b0_001: alu_op = ALU_SLL;
        4'b0_101: alu_op = ALU_SRL;
        4'b1_101: alu_op = ALU_SRA;
        4'b0_010: alu_op = ALU_SLT;
        4'b0_011: alu_op = ALU_SLTU;
        4'b0_100: alu_op = ALU_XOR;
        4'b0_110: alu_op = ALU_OR;
        4'b0_111: alu_op = ALU_AND;
        default:  alu_op = ALU_ADD;
      endcase
    end else if (is_branch) begin
      alu_op = ALU_SUB;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_FETCH;
      wait_cnt_q  <= '0;
      bus_error_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      bus_error_q <= bus_error_d;
      illegal_q   <= illegal_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bus_error_d = bus_error_q;
    illegal_d   = illegal_q;
    case (state_q)
      S_FETCH: begin
        if (imemReady) begin
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d     = S_TRAP;
          bus_error_d = 1'b1;
        end
      end
      S_DECODE: begin
        if (known) begin
          state_d = S_EXECUTE;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          state_d   = S_TRAP;
          illegal_d = 1'b1;
`else
          state_d   = S_FETCH;
`endif
        end
      end
      S_EXECUTE: begin
        if (is_load || is_store) state_d = S_MEM;
        else if (is_branch)      state_d = S_FETCH;
        else                     state_d = S_WB;
      end
      S_MEM: begin
        if (dmemReady) begin
          state_d = is_load ? S_WB : S_FETCH;
        end else if (timeout) begin
          state_d     = S_TRAP;
          bus_error_d = 1'b1;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
    wait_cnt_d = (waiting && state_d == state_q) ? wait_cnt_q + TO_CNT_W'(1) : '0;
  end

  always_comb begin
    imemReq    = 1'b0;
    irLoad     = 1'b0;
    pcEn       = 1'b0;
    regFileWe  = 1'b0;
    aluSrcSel  = 1'b0;
    aluControl = '0;
    rfWdSel    = 3'd0;
    pcSrcSel   = 2'd0;
    branch     = 1'b0;
    dataRe     = 1'b0;
    dataWe     = 1'b0;
    case (state_q)
      S_FETCH: begin
        imemReq = 1'b1;
        irLoad  = imemReady && !reset;
      end
      S_DECODE: begin
`ifndef ILLEGAL_TRAP_EN
        pcEn = !known;
`endif
      end
      S_EXECUTE: begin
        aluControl = ALU_CTRL_W'(alu_op);
        aluSrcSel  = is_load | is_store | is_i | is_jalr;
        if (is_branch) begin
          branch   = 1'b1;
          pcSrcSel = 2'd1;
          pcEn     = 1'b1;
        end
      end
      S_MEM: begin
        aluControl = ALU_CTRL_W'(alu_op);
        dataRe     = is_load;
        dataWe     = is_store;
        pcEn       = is_store && dmemReady;
      end
      S_WB: begin
        aluControl = ALU_CTRL_W'(alu_op);
        regFileWe  = 1'b1;
        pcEn       = 1'b1;
        if (is_load)                rfWdSel = 3'd1;
        else if (is_lui)            rfWdSel = 3'd2;
        else if (is_jal || is_jalr) rfWdSel = 3'd3;
        else if (is_auipc)          rfWdSel = 3'd4;
        if (is_jal)       pcSrcSel = 2'd1;
        else if (is_jalr) pcSrcSel = 2'd2;
      end
      default: ;
    endcase
  end

  assign illegalInstr = illegal_q;
  assign busError     = bus_error_q;

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// tb/tb_multi_cycle_control_unit.sv - directed-vector bench with per-cycle model for multi_cycle_control_unit
module tb_multi_cycle_control_unit;

  localparam int TO = 4;

  typedef struct packed {
    logic       imem_req;
    logic       ir_load;
    logic       pc_en;
    logic       rf_we;
    logic       alu_src;
    logic [3:0] alu;
    logic [2:0] wd;
    logic [1:0] pc_src;
    logic       br;
    logic       d_re;
    logic       d_we;
    logic       ill;
    logic       berr;
  } outv_t;

  typedef struct packed {
    logic        rst;
    logic [31:0] ins;
    logic        ir;
    logic        dr;
  } stim_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instrCode = 32'h0;
  logic        imemReady = 1'b0;
  logic        dmemReady = 1'b0;
  logic        imemReq, irLoad, pcEn, regFileWe, aluSrcSel, branch, dataRe, dataWe;
  logic        illegalInstr, busError;
  logic [3:0]  aluControl;
  logic [2:0]  rfWdSel;
  logic [1:0]  pcSrcSel;

  always #5 clk = ~clk;

  multi_cycle_control_unit #(
    .ALU_CTRL_W  (4),
    .WAIT_TIMEOUT(TO),
    .TO_CNT_W    (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .instrCode   (instrCode),
    .imemReady   (imemReady),
    .dmemReady   (dmemReady),
    .imemReq     (imemReq),
    .irLoad      (irLoad),
    .pcEn        (pcEn),
    .regFileWe   (regFileWe),
    .aluSrcSel   (aluSrcSel),
    .aluControl  (aluControl),
    .rfWdSel     (rfWdSel),
    .pcSrcSel    (pcSrcSel),
    .branch      (branch),
    .dataRe      (dataRe),
    .dataWe      (dataWe),
    .illegalInstr(illegalInstr),
    .busError    (busError)
  );

  outv_t dut_v;
  assign dut_v = {imemReq, irLoad, pcEn, regFileWe, aluSrcSel, aluControl, rfWdSel,
                  pcSrcSel, branch, dataRe, dataWe, illegalInstr, busError};

  stim_t stim_q[$];
  outv_t exp_q[$];
  outv_t care_q[$];
  outv_t cur_exp, cur_care;
  bit    chk_en = 1'b0;
  int    step = 0;
  int    total = 0, bad = 0;
  int    n_re = 0, n_we = 0, n_rf = 0, n_br = 0, n_berr_rise = 0;
  logic  prev_berr = 1'b0;
  bit    ill_m = 1'b0, berr_m = 1'b0;

  task automatic check(input string nm, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  function automatic outv_t idle_v();
    outv_t v;
    v = '0;
    v.ill  = ill_m;
    v.berr = berr_m;
    return v;
  endfunction

  function automatic outv_t care_ctl();
    outv_t c;
    c = '1;
    c.alu     = '0;
    c.alu_src = 1'b0;
    c.wd      = '0;
    c.pc_src  = '0;
    return c;
  endfunction

  function automatic logic [3:0] model_alu(input logic [31:0] ins);
    logic [6:0] op;
    logic [2:0] f3;
    logic       alt;
    op = ins[6:0];
    f3 = ins[14:12];
    if (op == 7'b1100011) return 4'd1;
    if (op == 7'b0110011)      alt = ins[30];
    else if (op == 7'b0010011) alt = (f3 == 3'd5) && ins[30];
    else return 4'd0;
    case (f3)
      3'd0:    return alt ? 4'd1 : 4'd0;
      3'd1:    return alt ? 4'd0 : 4'd2;
      3'd2:    return alt ? 4'd0 : 4'd5;
      3'd3:    return alt ? 4'd0 : 4'd6;
      3'd4:    return alt ? 4'd0 : 4'd7;
      3'd5:    return alt ? 4'd4 : 4'd3;
      3'd6:    return alt ? 4'd0 : 4'd8;
      default: return alt ? 4'd0 : 4'd9;
    endcase
  endfunction

  task automatic push(input logic rst, input logic [31:0] ins, input logic ir, input logic dr,
                      input outv_t e, input outv_t c);
    stim_t s;
    s.rst = rst; s.ins = ins; s.ir = ir; s.dr = dr;
    stim_q.push_back(s);
    exp_q.push_back(e);
    care_q.push_back(c);
  endtask

  task automatic plan_reset(input int n);
    outv_t e;
    ill_m  = 1'b0;
    berr_m = 1'b0;
    for (int k = 0; k < n; k++) begin
      e = idle_v();
      e.imem_req = 1'b1;
      push(1'b1, 32'hDEADBEEF, 1'b1, 1'b1, e, '1);
    end
  endtask

  task automatic plan_trap(input logic [31:0] ins, input int n);
    for (int k = 0; k < n; k++) push(1'b0, ins, 1'b1, 1'b1, idle_v(), care_ctl());
  endtask

  // abort >= 0 asserts reset in place of that MEM-wait cycle
  task automatic plan_instr(input logic [31:0] ins, input int iw, input int dw, input int abort);
    outv_t e, c;
    logic [6:0] op;
    bit ld, st, br, ia, lui, aui, jal, jalr, known;
    op   = ins[6:0];
    ld   = (op == 7'b0000011);
    st   = (op == 7'b0100011);
    br   = (op == 7'b1100011);
    ia   = (op == 7'b0010011);
    lui  = (op == 7'b0110111);
    aui  = (op == 7'b0010111);
    jal  = (op == 7'b1101111);
    jalr = (op == 7'b1100111);
    known = ld | st | br | ia | lui | aui | jal | jalr | (op == 7'b0110011);
    for (int k = 0; k < iw; k++) begin
      e = idle_v();
      e.imem_req = 1'b1;
      push(1'b0, ins, 1'b0, 1'b0, e, '1);
      if (k == TO) begin
        berr_m = 1'b1;
        plan_trap(ins, 3);
        plan_reset(2);
        return;
      end
    end
    e = idle_v();
    e.imem_req = 1'b1;
    e.ir_load  = 1'b1;
    push(1'b0, ins, 1'b1, 1'b0, e, '1);
    e = idle_v();
    c = care_ctl();
    if (!known) begin
`ifdef ILLEGAL_TRAP_EN
      push(1'b0, ins, 1'b1, 1'b1, e, c);
      ill_m = 1'b1;
      plan_trap(ins, 2);
      plan_reset(2);
`else
      e.pc_en  = 1'b1;
      c.pc_src = '1;
      push(1'b0, ins, 1'b1, 1'b1, e, c);
`endif
      return;
    end
    push(1'b0, ins, 1'b1, 1'b1, e, c);
    e = idle_v();
    c = care_ctl();
    c.alu     = '1;
    c.alu_src = 1'b1;
    e.alu     = model_alu(ins);
    e.alu_src = ld | st | ia | jalr;
    if (br) begin
      e.br     = 1'b1;
      e.pc_src = 2'd1;
      e.pc_en  = 1'b1;
      c.pc_src = '1;
      push(1'b0, ins, 1'b1, 1'b1, e, c);
      return;
    end
    push(1'b0, ins, 1'b1, 1'b1, e, c);
    if (ld || st) begin
      for (int k = 0; k <= dw; k++) begin
        if (k == abort) begin
          plan_reset(2);
          return;
        end
        e = idle_v();
        c = care_ctl();
        e.d_re = ld;
        e.d_we = st;
        if (k == dw && st) begin
          e.pc_en  = 1'b1;
          c.pc_src = '1;
        end
        push(1'b0, ins, 1'b1, (k == dw), e, c);
        if (k == TO && k != dw) begin
          berr_m = 1'b1;
          plan_trap(ins, 2);
          plan_reset(2);
          return;
        end
        if (k == dw && st) return;
      end
    end
    e = idle_v();
    c = care_ctl();
    c.wd     = '1;
    c.pc_src = '1;
    e.rf_we  = 1'b1;
    e.pc_en  = 1'b1;
    e.wd     = ld ? 3'd1 : lui ? 3'd2 : (jal || jalr) ? 3'd3 : aui ? 3'd4 : 3'd0;
    e.pc_src = jal ? 2'd1 : jalr ? 2'd2 : 2'd0;
    push(1'b0, ins, 1'b1, 1'b1, e, c);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      total++;
      if (((dut_v ^ cur_exp) & cur_care) !== '0) begin
        bad++;
        $display("FAIL step %0d outputs got=%h want=%h care=%h", step, dut_v, cur_exp, cur_care);
      end
      n_re        += int'(dataRe);
      n_we        += int'(dataWe);
      n_rf        += int'(regFileWe);
      n_br        += int'(branch);
      n_berr_rise += int'(busError && !prev_berr);
      prev_berr    = busError;
    end
  end

  initial begin
    int n0;
    imemReady = 1'b1;
    #2;
    check("reset_imemReq", int'(imemReq), 1);
    check("reset_irLoad", int'(irLoad), 0);

    check("model_alu_sub", int'(model_alu(32'h402081B3)), 1);
    check("model_alu_srai", int'(model_alu(32'h4020D193)), 4);
    check("model_alu_addi_b30", int'(model_alu(32'h40008193)), 0);
    check("model_alu_xori", int'(model_alu(32'h0040C193)), 7);

    plan_reset(2);
    n0 = stim_q.size(); plan_instr(32'h002081B3, 0, 0, -1);
    check("model_add_len", stim_q.size() - n0, 4);
    n0 = stim_q.size(); plan_instr(32'h402081B3, 1, 0, -1);
    check("model_sub_len", stim_q.size() - n0, 5);
    plan_instr(32'h4020D193, 0, 0, -1);
    plan_instr(32'h40008193, 0, 0, -1);
    plan_instr(32'h0040C193, 0, 0, -1);
    plan_instr(32'h0020B1B3, 0, 0, -1);
    n0 = stim_q.size(); plan_instr(32'h0000A283, 0, 3, -1);
    check("model_lw_len", stim_q.size() - n0, 8);
    plan_instr(32'h0000A283, 0, TO, -1);
    n0 = stim_q.size(); plan_instr(32'h0050A223, 0, 0, -1);
    check("model_sw_len", stim_q.size() - n0, 4);
    plan_instr(32'h0050A223, 0, 2, -1);
    n0 = stim_q.size(); plan_instr(32'h00000463, 0, 0, -1);
    check("model_beq_len", stim_q.size() - n0, 3);
    plan_instr(32'h123452B7, 0, 0, -1);
    plan_instr(32'h00001297, 0, 0, -1);
    plan_instr(32'h008000EF, 0, 0, -1);
    plan_instr(32'h000080E7, 0, 0, -1);
    n0 = stim_q.size(); plan_instr(32'h00000000, 0, 0, -1);
`ifdef ILLEGAL_TRAP_EN
    check("model_illegal_len", stim_q.size() - n0, 6);
`else
    check("model_nop_len", stim_q.size() - n0, 2);
`endif
    plan_instr(32'h002081B3, TO, 0, -1);
    plan_instr(32'h0000A283, 0, 9, 2);
    plan_instr(32'h002081B3, 7, 0, -1);
    plan_instr(32'h002081B3, 0, 0, -1);
    plan_instr(32'h0050A223, 0, 9, -1);
    plan_instr(32'h002081B3, 0, 0, -1);

    for (int i = 0; i < stim_q.size(); i++) begin
      @(posedge clk);
      #1;
      reset     = stim_q[i].rst;
      instrCode = stim_q[i].ins;
      imemReady = stim_q[i].ir;
      dmemReady = stim_q[i].dr;
      cur_exp   = exp_q[i];
      cur_care  = care_q[i];
      step      = i;
      chk_en    = 1'b1;
    end
    @(posedge clk);
    #1;
    chk_en = 1'b0;
    @(negedge clk);
    check("count_regFileWe", n_rf, 15);
    check("count_dataRe", n_re, 11);
    check("count_dataWe", n_we, 9);
    check("count_branch", n_br, 1);
    check("count_busError_rise", n_berr_rise, 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
